// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cache-line to pmem burst adapter.
// Line geometry is fixed here so the FSM and any user agree on beat slicing.
package cacheline_adapter_pkg;

  localparam int s_offset  = 5;
  localparam int s_line    = 8 * (2 ** s_offset);
  localparam int s_beat    = 64;
  localparam int num_beats = s_line / s_beat;
  localparam int cnt_w     = $clog2(num_beats);

  // Clears the byte-offset bits so every burst starts on a line boundary.
  localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    s_idle,
    s_read,
    s_write,
    s_done
  } adapter_state_t;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Converts one whole-line cache request into a fixed burst of narrow pmem beats.
// Reads assemble the line LSB-beat first; writes stream a latched copy of the dirty line.
module cacheline_burst_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ca_addr,
  input  logic              ca_read,
  input  logic              ca_write,
  input  logic [s_line-1:0] ca_wdata,
  output logic [s_line-1:0] ca_rdata,
  output logic              ca_resp,
  output logic [31:0]       pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_beat-1:0] pmem_wdata,
  input  logic [s_beat-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  adapter_state_t    state_q, state_d;
  logic [cnt_w-1:0]  count_q, count_d;
  logic [s_line-1:0] buffer_q, buffer_d;
  logic [31:0]       addr_q, addr_d;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    count_d  = count_q;
    buffer_d = buffer_q;
    addr_d   = addr_q;

    unique case (state_q)
      s_idle: begin
        if (ca_write) begin
          buffer_d = ca_wdata;
          addr_d   = ca_addr & line_mask;
          count_d  = '0;
          state_d  = s_write;
        end else if (ca_read) begin
          addr_d   = ca_addr & line_mask;
          count_d  = '0;
          state_d  = s_read;
        end
      end
      s_read: begin
        if (pmem_resp) begin
          buffer_d[int'(count_q) * s_beat +: s_beat] = pmem_rdata;
          // Wraps to zero on the last beat because num_beats is a power of two.
          count_d = count_q + cnt_w'(1);
          if (count_q == last_beat) state_d = s_done;
        end
      end
      s_write: begin
        if (pmem_resp) begin
          count_d = count_q + cnt_w'(1);
          if (count_q == last_beat) state_d = s_done;
        end
      end
      s_done:  state_d = s_idle;
      default: state_d = s_idle;
    endcase
  end

  // NOTE: the line buffer is an ordinary register, not a RAM, so it is cleared by reset like the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= s_idle;
      count_q  <= '0;
      buffer_q <= '0;
      addr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      state_q  <= state_d;
      count_q  <= count_d;
      buffer_q <= buffer_d;
      addr_q   <= addr_d;
    end
  end

  // Outputs decode registered state only, so reset drops the bus requests asynchronously.
  assign pmem_read  = (state_q == s_read);
  assign pmem_write = (state_q == s_write);
  assign ca_resp    = (state_q == s_done);
  assign pmem_addr  = (pmem_read || pmem_write) ? addr_q : 32'h0;
  assign ca_rdata   = buffer_q;
  assign pmem_wdata = buffer_q[int'(count_q) * s_beat +: s_beat];

endmodule
